// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: program memory, PC and valid/ready instruction issue.
// Optional macro INST_PARITY_EN adds per-word even parity and a parity_err output.
module inst_fetch_unit #(
  parameter int         DEPTH       = 256,
  parameter int         PC_W        = 8,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_wdata,
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
`ifdef INST_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rd_word_s;
  logic            mem_we_s;
  logic            hs_s;
  logic            is_halt_s;

`ifdef INST_PARITY_EN
  logic            mem_par_q [DEPTH];
  logic            rd_par_s;
  logic            par_bad_s;
  logic            parity_err_q, parity_err_d;

  function automatic logic even_par(input logic [31:0] w);
    return ^w;
  endfunction
`endif

  // Program writes are only legal while the unit is not executing.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[prog_addr] <= prog_wdata;
`ifdef INST_PARITY_EN
      mem_par_q[prog_addr] <= even_par(prog_wdata);
`endif
    end
  end

  // Next-state, PC and issue-register logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    rd_word_s    = mem_q[pc_q];
    hs_s         = inst_valid_q & inst_ready;
    is_halt_s    = (inst_q[31:29] == HALT_OPCODE);
    mem_we_s     = prog_we & ((state_q == S_IDLE) | (state_q == S_HALTED));
`ifdef INST_PARITY_EN
    rd_par_s     = mem_par_q[pc_q];
    par_bad_s    = (even_par(rd_word_s) != rd_par_s);
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
`ifdef INST_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        // A redirect here discards the read and refetches at the new target.
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
`ifdef INST_PARITY_EN
        else if (par_bad_s) begin
          state_d      = S_HALTED;
          parity_err_d = 1'b1;
        end
`endif
        else begin
          state_d      = S_ISSUE;
          inst_d       = rd_word_s;
          inst_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // Halt beats redirect, redirect beats sequential advance.
        if (hs_s && is_halt_s) begin
          state_d = S_HALTED;
        end else if (redirect_valid) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc;
        end else if (hs_s) begin
          state_d = S_FETCH;
          pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
          inst_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d == S_FETCH) | (state_d == S_ISSUE);
    halted_d = (state_d == S_HALTED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= {PC_W{1'b0}};
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
`ifdef INST_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
`ifdef INST_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
`ifdef INST_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of PC flow and instruction delivery.
module tb_inst_fetch_unit;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'd0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'd0;
  logic [31:0] prog_wdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
`ifdef INST_PARITY_EN
  logic        parity_err;
`endif

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef INST_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  model_pc;
  bit          exp_valid;
  bit          model_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic begin_run(input logic [7:0] p);
    start = 1'b1; start_pc = p;
    step();
    start = 1'b0;
    model_pc = p; exp_valid = 1'b0; model_halted = 1'b0;
  endtask

  // Cycle loop from the current sample: checks outputs, drives inputs, advances model.
  task automatic run(input int budget, input int rdy_pct, input int rd_pct, input bit noise,
                     input bit expect_halt, output int n_hs, output int min_gap, output int max_gap);
    int  last_hs;
    bit  hs;
    n_hs = 0; min_gap = 1000; max_gap = 0; last_hs = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      check("halted", halted, model_halted);
      if (model_halted) break;
      check("busy", busy, 1'b1);
      check("pc", pc, model_pc);
      check("inst_valid", inst_valid, exp_valid);
      if (inst_valid) check("inst", inst, model_mem[model_pc]);
      inst_ready     = ($urandom_range(99) < rdy_pct);
      redirect_valid = ($urandom_range(99) < rd_pct);
      redirect_pc    = 8'($urandom);
      start          = noise && ($urandom_range(3) == 0);
      start_pc       = 8'($urandom);
      prog_we        = noise && ($urandom_range(1) == 0);
      prog_addr      = 8'($urandom);
      prog_wdata     = $urandom;
      hs = inst_valid && inst_ready;
      if (hs) begin
        n_hs++;
        if (last_hs >= 0) begin
          if (cyc - last_hs < min_gap) min_gap = cyc - last_hs;
          if (cyc - last_hs > max_gap) max_gap = cyc - last_hs;
        end
        last_hs = cyc;
      end
      if (hs && model_mem[model_pc][31:29] == 3'b111) begin
        model_halted = 1'b1; exp_valid = 1'b0;
      end else if (redirect_valid) begin
        model_pc = redirect_pc; exp_valid = 1'b0;
      end else if (hs) begin
        model_pc = model_pc + 8'd1; exp_valid = 1'b0;
      end else begin
        exp_valid = 1'b1;
      end
      step();
    end
    inst_ready = 1'b0; redirect_valid = 1'b0; start = 1'b0; prog_we = 1'b0;
    if (expect_halt) check("halt_reached", halted, 1'b1);
    if (model_halted) begin
      check("halt_pc", pc, model_pc);
      check("halt_valid", inst_valid, 1'b0);
      check("halt_busy", busy, 1'b0);
    end
  endtask

  initial begin
    int          n, mn, mx;
    logic [31:0] w, held;

    // Reset values
    step(); step();
    check("rst_pc", pc, 8'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
    step();

    // Random non-halt program, then the directed words
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      w[31:29] = 3'($urandom_range(6));
      write_word(8'(i), w);
    end
    write_word(8'd0, 32'h2100_0004);
    write_word(8'd1, 32'h4200_0008);
    write_word(8'd2, 32'hE000_0000);
    write_word(8'd6, 32'hE000_0006);
    write_word(8'd9, 32'hE000_0009);

    // Straight-line run: three handshakes two cycles apart, then halt at pc 2
    begin_run(8'd0);
    run(40, 100, 0, 0, 1, n, mn, mx);
    check("c_hs_count", n, 3);
    check("c_min_gap", mn, 2);
    check("c_max_gap", mx, 2);
    check("c_pc", pc, 8'd2);

    // Redirect while halted is ignored
    redirect_valid = 1'b1; redirect_pc = 8'd77;
    step();
    redirect_valid = 1'b0;
    check("halted_redirect_pc", pc, 8'd2);
    check("halted_redirect_halted", halted, 1'b1);

    // Stall on the first instruction for five cycles
    begin_run(8'd0);
    step();
    check("stall_valid0", inst_valid, 1'b1);
    check("stall_inst0", inst, model_mem[0]);
    held = inst;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_inst", inst, held);
      check("stall_valid", inst_valid, 1'b1);
      check("stall_pc", pc, 8'd0);
    end
    exp_valid = 1'b1;
    run(40, 100, 0, 0, 1, n, mn, mx);

    // Redirect during ISSUE without handshake squashes the instruction
    begin_run(8'd0);
    step();
    check("rd_valid_before", inst_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 8'd8;
    step();
    redirect_valid = 1'b0;
    check("rd_squash", inst_valid, 1'b0);
    model_pc = 8'd8; exp_valid = 1'b0;
    run(40, 100, 0, 0, 1, n, mn, mx);
    check("rd_hs_count", n, 2);
    check("rd_halt_pc", pc, 8'd9);

    // Handshake and redirect in the same cycle: redirect beats pc+1
    begin_run(8'd0);
    step();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd5;
    step();
    redirect_valid = 1'b0;
    check("hsrd_pc", pc, 8'd5);
    model_pc = 8'd5; exp_valid = 1'b0;
    run(40, 100, 0, 0, 1, n, mn, mx);
    check("hsrd_hs_count", n, 2);
    check("hsrd_halt_pc", pc, 8'd6);

    // PC wrap from DEPTH-1 to 0
    begin_run(8'd255);
    run(40, 100, 0, 0, 1, n, mn, mx);
    check("wrap_hs_count", n, 4);
    check("wrap_halt_pc", pc, 8'd2);

    // Random traffic with writes and starts while busy, which must be ignored
    for (int k = 0; k < 6; k++) begin
      begin_run(8'($urandom));
      run(150, 60, 15, 1, 0, n, mn, mx);
      if (!model_halted) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst_pc", pc, 8'd0);
        check("rnd_rst_valid", inst_valid, 1'b0);
        rst_n = 1'b1;
        step();
      end
    end

    // Stored program survives busy-time writes
    begin_run(8'd0);
    run(40, 100, 0, 0, 1, n, mn, mx);
    check("post_noise_hs_count", n, 3);

    // Reset asserted during ISSUE drops the pending instruction at once
    begin_run(8'd20);
    step();
    check("rst_mid_valid_before", inst_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", inst_valid, 1'b0);
    check("rst_mid_pc", pc, 8'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_inst", inst, 32'd0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
